// File: rtl/div_ctrl_if.sv
// Divide-control bus between the EX stage, div_ctrl and the iterative divider.
// Signals:
//   div_req_i, div_signed_i, reg1_i, reg2_i, flush_i  - EX-stage request side
//   div_ready_i, div_result_i                         - divider result side
//   div_start_o, div_annul_o, div_signed_o,
//   div_opdata1_o, div_opdata2_o                      - divider command side
//   stallreq_o, whilo_o, hi_o, lo_o, busy_o           - pipeline/HI-LO side
// Modports: slave = div_ctrl, master = the environment driving it.
interface div_ctrl_if;
    localparam int unsigned DATA_W = 32;

    logic                  div_req_i;
    logic                  div_signed_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic                  flush_i;
    logic                  div_ready_i;
    logic [2*DATA_W-1:0]   div_result_i;

    logic                  div_start_o;
    logic                  div_annul_o;
    logic                  div_signed_o;
    logic [DATA_W-1:0]     div_opdata1_o;
    logic [DATA_W-1:0]     div_opdata2_o;
    logic                  stallreq_o;
    logic                  whilo_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  busy_o;

    modport slave (
        input  div_req_i, div_signed_i, reg1_i, reg2_i, flush_i,
               div_ready_i, div_result_i,
        output div_start_o, div_annul_o, div_signed_o, div_opdata1_o,
               div_opdata2_o, stallreq_o, whilo_o, hi_o, lo_o, busy_o
    );

    modport master (
        output div_req_i, div_signed_i, reg1_i, reg2_i, flush_i,
               div_ready_i, div_result_i,
        input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o,
               div_opdata2_o, stallreq_o, whilo_o, hi_o, lo_o, busy_o
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one DIV/DIVU through an external iterative divider.
// IDLE accepts a request and latches operands, BUSY holds div_start_o until
// the divider reports ready, DONE writes HI/LO for exactly one cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   dif  - div_ctrl_if.slave (request, divider handshake, HI/LO write)
// Optional build macro: DIVCTL_ZERO_FAST_EN - a zero divisor skips the divider
// and goes straight to DONE with HI = LO = 0.
module div_ctrl (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave dif
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic              start_q,  start_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] op1_q,    op1_d;
    logic [DATA_W-1:0] op2_q,    op2_d;
    logic [DATA_W-1:0] hi_q,     hi_d;
    logic [DATA_W-1:0] lo_q,     lo_d;

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (dif.div_req_i && !dif.flush_i) begin
                    // Operands stay frozen until IDLE: the divider reads the
                    // sign bits again when it finishes.
                    op1_d    = dif.reg1_i;
                    op2_d    = dif.reg2_i;
                    signed_d = dif.div_signed_i;
`ifdef DIVCTL_ZERO_FAST_EN
                    if (dif.reg2_i == '0) begin
                        state_d = DONE;
                        start_d = 1'b0;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        state_d = BUSY;
                        start_d = 1'b1;
                    end
`else
                    state_d = BUSY;
                    start_d = 1'b1;
`endif
                end
            end
            BUSY: begin
                // Flush wins over a coincident ready: the result is discarded.
                if (dif.flush_i) begin
                    state_d = IDLE;
                    start_d = 1'b0;
                end else if (dif.div_ready_i) begin
                    state_d = DONE;
                    start_d = 1'b0;
                    hi_d    = dif.div_result_i[2*DATA_W-1:DATA_W];
                    lo_d    = dif.div_result_i[DATA_W-1:0];
                end
            end
            DONE: begin
                // One start-low cycle lets the divider return to its free state;
                // a request still visible here is the one just served.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign dif.div_start_o   = start_q;
    assign dif.div_signed_o  = signed_q;
    assign dif.div_opdata1_o = op1_q;
    assign dif.div_opdata2_o = op2_q;
    assign dif.hi_o          = hi_q;
    assign dif.lo_o          = lo_q;

    // Combinational status, forced low while reset is held
    assign dif.busy_o      = ~rst & (state_q != IDLE);
    assign dif.whilo_o     = ~rst & (state_q == DONE) & ~dif.flush_i;
    assign dif.stallreq_o  = ~rst & dif.div_req_i & (state_q != DONE);
    assign dif.div_annul_o = ~rst & dif.flush_i & (state_q == BUSY);
endmodule
